// File: rtl/mult_pipe_tap_if.sv
// rtl/mult_pipe_tap_if.sv - operand/product bundle for the mult_pipe_tap multiplier wrapper
//
// Purpose: groups the clock enable, operand inputs, product outputs and
// fanout taps of mult_pipe_tap so the block and its user share one port.
// Clock and reset stay outside as plain ports on the module.
//
// Signals:
//   CE         clock enable for every pipeline stage
//   IN_VALID   A/B carry a sample this cycle
//   A, B       operands (A_WIDTH, B_WIDTH bits)
//   ACC_CLR    accumulator restart, present only with MULT_PIPE_TAP_ACCUMULATE_EN
//   Z          product (A_WIDTH+B_WIDTH bits)
//   OUT_VALID  Z carries a valid sample
//   XA         inverted low bits of A at the multiplier input (TAP_WIDTH)
//   XZ         low bits of the unregistered product (TAP_WIDTH)
//
// Modports: master drives operands and reads results; slave is the multiplier.
interface mult_pipe_tap_if #(
    parameter int A_WIDTH   = 9,
    parameter int B_WIDTH   = 9,
    parameter int TAP_WIDTH = 4
);
    logic                       CE;
    logic                       IN_VALID;
    logic [A_WIDTH-1:0]         A;
    logic [B_WIDTH-1:0]         B;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
    logic                       ACC_CLR;
`endif
    logic [A_WIDTH+B_WIDTH-1:0] Z;
    logic                       OUT_VALID;
    logic [TAP_WIDTH-1:0]       XA;
    logic [TAP_WIDTH-1:0]       XZ;

    modport master (
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
        output ACC_CLR,
`endif
        output CE,
        output IN_VALID,
        output A,
        output B,
        input  Z,
        input  OUT_VALID,
        input  XA,
        input  XZ
    );

    modport slave (
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
        input  ACC_CLR,
`endif
        input  CE,
        input  IN_VALID,
        input  A,
        input  B,
        output Z,
        output OUT_VALID,
        output XA,
        output XZ
    );
endinterface

// File: rtl/mult_pipe_tap.sv
// rtl/mult_pipe_tap.sv - parametrised pipelined multiplier with operand/product fanout taps
//
// Purpose: a MULT9X9-style multiplier generalised to configurable operand
// widths, input/output register depth, signedness and a parallel valid
// chain. XA taps the registered operand and XZ taps the combinational
// product; both stay live outputs so the register-sharing boundary around
// the DSP remains visible.
//
// Optional feature (macro MULT_PIPE_TAP_ACCUMULATE_EN): adds bus.ACC_CLR,
// pipelined with the valid bit, and turns the last output stage into a
// wrapping accumulator. Needs OUT_STAGES >= 1.
//
// Ports:
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous active-high reset, overrides CE
//   bus   mult_pipe_tap_if.slave: CE, IN_VALID, A, B, [ACC_CLR] in;
//         Z, OUT_VALID, XA, XZ out
module mult_pipe_tap #(
    parameter int A_WIDTH    = 9,
    parameter int B_WIDTH    = 9,
    parameter int IN_STAGES  = 1,
    parameter int OUT_STAGES = 1,
    parameter int SIGNED     = 0,
    parameter int TAP_WIDTH  = 4
) (
    input  logic           CLK,
    input  logic           RST,
    mult_pipe_tap_if.slave bus
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    // Elaboration-time parameter checks
    generate
        if (IN_STAGES < 0 || IN_STAGES > 2) begin : g_bad_in_stages
            $error("mult_pipe_tap: IN_STAGES must be 0..2");
        end
        if (OUT_STAGES < 0 || OUT_STAGES > 2) begin : g_bad_out_stages
            $error("mult_pipe_tap: OUT_STAGES must be 0..2");
        end
        if (TAP_WIDTH < 1 || TAP_WIDTH > A_WIDTH) begin : g_bad_tap_width
            $error("mult_pipe_tap: TAP_WIDTH must be 1..A_WIDTH");
        end
        if (A_WIDTH < 2 || A_WIDTH > 18 || B_WIDTH < 2 || B_WIDTH > 18) begin : g_bad_width
            $error("mult_pipe_tap: operand widths must be 2..18");
        end
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
        if (OUT_STAGES < 1) begin : g_bad_acc_depth
            $error("mult_pipe_tap: accumulator needs OUT_STAGES >= 1");
        end
`endif
    endgenerate

    // Values as seen at the multiplier input (after IN_STAGES)
    logic [A_WIDTH-1:0] a_m;
    logic [B_WIDTH-1:0] b_m;
    logic               v_m;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
    logic               c_m;
`endif

    // Input register chain
    generate
        if (IN_STAGES == 0) begin : g_in_comb
            assign a_m = bus.A;
            assign b_m = bus.B;
            assign v_m = bus.IN_VALID;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
            assign c_m = bus.ACC_CLR;
`endif
        end else begin : g_in_reg
            logic [A_WIDTH-1:0]   a_q [IN_STAGES];
            logic [B_WIDTH-1:0]   b_q [IN_STAGES];
            logic [IN_STAGES-1:0] v_q;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
            logic [IN_STAGES-1:0] c_q;
`endif

            // Data stages shift on every enabled edge, valid or not; only
            // the 1-bit valid chain says which samples mean anything.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < IN_STAGES; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                    v_q <= '0;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
                    c_q <= '0;
`endif
                end else if (bus.CE) begin
                    a_q[0] <= bus.A;
                    b_q[0] <= bus.B;
                    v_q[0] <= bus.IN_VALID;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
                    c_q[0] <= bus.ACC_CLR;
`endif
                    for (int i = 1; i < IN_STAGES; i++) begin
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                        v_q[i] <= v_q[i-1];
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
                        c_q[i] <= c_q[i-1];
`endif
                    end
                end
            end

            assign a_m = a_q[IN_STAGES-1];
            assign b_m = b_q[IN_STAGES-1];
            assign v_m = v_q[IN_STAGES-1];
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
            assign c_m = c_q[IN_STAGES-1];
`endif
        end
    endgenerate

    // Multiplier: both operands are extended to the full product width, so
    // the low P_WIDTH bits of the product are exact for either signedness.
    logic [P_WIDTH-1:0] a_ext;
    logic [P_WIDTH-1:0] b_ext;
    logic [P_WIDTH-1:0] prod;

    always_comb begin
        if (SIGNED != 0) begin
            a_ext = {{B_WIDTH{a_m[A_WIDTH-1]}}, a_m};
            b_ext = {{A_WIDTH{b_m[B_WIDTH-1]}}, b_m};
        end else begin
            a_ext = {{B_WIDTH{1'b0}}, a_m};
            b_ext = {{A_WIDTH{1'b0}}, b_m};
        end
        prod = a_ext * b_ext;
    end

    // Fanout taps straddling the DSP boundary
    assign bus.XA = ~a_m[TAP_WIDTH-1:0];
    assign bus.XZ = prod[TAP_WIDTH-1:0];

    // Output register chain
    generate
        if (OUT_STAGES == 0) begin : g_out_comb
            assign bus.Z         = prod;
            assign bus.OUT_VALID = v_m;
        end else begin : g_out_reg
            logic [P_WIDTH-1:0]    z_q  [OUT_STAGES];
            logic [P_WIDTH-1:0]    z_in [OUT_STAGES];
            logic [OUT_STAGES-1:0] v_q;
            logic [OUT_STAGES-1:0] v_in;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
            logic [OUT_STAGES-1:0] c_q;
            logic [OUT_STAGES-1:0] c_in;
`endif

            // Stage inputs: stage 0 takes the raw product, later stages
            // take the stage before them.
            always_comb begin
                v_in = '0;
                for (int i = 0; i < OUT_STAGES; i++) begin
                    z_in[i] = '0;
                end
                z_in[0] = prod;
                v_in[0] = v_m;
                for (int i = 1; i < OUT_STAGES; i++) begin
                    z_in[i] = z_q[i-1];
                    v_in[i] = v_q[i-1];
                end
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
                c_in    = '0;
                c_in[0] = c_m;
                for (int i = 1; i < OUT_STAGES; i++) begin
                    c_in[i] = c_q[i-1];
                end
`endif
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < OUT_STAGES; i++) begin
                        z_q[i] <= '0;
                    end
                    v_q <= '0;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
                    c_q <= '0;
`endif
                end else if (bus.CE) begin
                    for (int i = 0; i < OUT_STAGES; i++) begin
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
                        // Last stage accumulates valid products only; the
                        // sum wraps at the product width.
                        if (i == OUT_STAGES - 1) begin
                            if (v_in[i]) begin
                                z_q[i] <= (c_in[i] ? '0 : z_q[i]) + z_in[i];
                            end
                        end else begin
                            z_q[i] <= z_in[i];
                        end
                        c_q[i] <= c_in[i];
`else
                        z_q[i] <= z_in[i];
`endif
                        v_q[i] <= v_in[i];
                    end
                end
            end

            assign bus.Z         = z_q[OUT_STAGES-1];
            assign bus.OUT_VALID = v_q[OUT_STAGES-1];
        end
    endgenerate
endmodule

// File: tb/tb_mult_pipe_tap.sv
// tb/tb_mult_pipe_tap.sv - self-checking bench for mult_pipe_tap
module tb_mult_pipe_tap;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb [$];

    // Default 9x9 unsigned, IN=1, OUT=1
    mult_pipe_tap_if #(.A_WIDTH(9), .B_WIDTH(9), .TAP_WIDTH(4)) if0 ();
    mult_pipe_tap #(.A_WIDTH(9), .B_WIDTH(9), .IN_STAGES(1), .OUT_STAGES(1),
                    .SIGNED(0), .TAP_WIDTH(4))
        u0 (.CLK(CLK), .RST(RST), .bus(if0));

    // Signed 9x9
    mult_pipe_tap_if #(.A_WIDTH(9), .B_WIDTH(9), .TAP_WIDTH(4)) if1 ();
    mult_pipe_tap #(.A_WIDTH(9), .B_WIDTH(9), .IN_STAGES(1), .OUT_STAGES(1),
                    .SIGNED(1), .TAP_WIDTH(4))
        u1 (.CLK(CLK), .RST(RST), .bus(if1));

    // Depth sweep instances, 18x4 unsigned, shared stimulus
    logic [17:0] da;
    logic [3:0]  db;
    logic        dvin;
    logic        dce;
    logic [3:0]  dv;
    logic [21:0] dz [4];

`ifndef MULT_PIPE_TAP_ACCUMULATE_EN
    localparam int FIRST_D = 0;
    mult_pipe_tap_if #(.A_WIDTH(18), .B_WIDTH(4), .TAP_WIDTH(4)) ifd00 ();
    mult_pipe_tap #(.A_WIDTH(18), .B_WIDTH(4), .IN_STAGES(0), .OUT_STAGES(0),
                    .SIGNED(0), .TAP_WIDTH(4))
        ud00 (.CLK(CLK), .RST(RST), .bus(ifd00));
    mult_pipe_tap_if #(.A_WIDTH(18), .B_WIDTH(4), .TAP_WIDTH(4)) ifd20 ();
    mult_pipe_tap #(.A_WIDTH(18), .B_WIDTH(4), .IN_STAGES(2), .OUT_STAGES(0),
                    .SIGNED(0), .TAP_WIDTH(4))
        ud20 (.CLK(CLK), .RST(RST), .bus(ifd20));
    assign ifd00.A = da;  assign ifd00.B = db;  assign ifd00.IN_VALID = dvin;  assign ifd00.CE = dce;
    assign ifd20.A = da;  assign ifd20.B = db;  assign ifd20.IN_VALID = dvin;  assign ifd20.CE = dce;
    assign dv[0] = ifd00.OUT_VALID;
    assign dv[1] = ifd20.OUT_VALID;
    assign dz[0] = ifd00.Z;
    assign dz[1] = ifd20.Z;
`else
    localparam int FIRST_D = 2;
    assign dv[1:0] = 2'b00;
    assign dz[0]   = '0;
    assign dz[1]   = '0;
`endif

    mult_pipe_tap_if #(.A_WIDTH(18), .B_WIDTH(4), .TAP_WIDTH(4)) ifd02 ();
    mult_pipe_tap #(.A_WIDTH(18), .B_WIDTH(4), .IN_STAGES(0), .OUT_STAGES(2),
                    .SIGNED(0), .TAP_WIDTH(4))
        ud02 (.CLK(CLK), .RST(RST), .bus(ifd02));
    mult_pipe_tap_if #(.A_WIDTH(18), .B_WIDTH(4), .TAP_WIDTH(4)) ifd22 ();
    mult_pipe_tap #(.A_WIDTH(18), .B_WIDTH(4), .IN_STAGES(2), .OUT_STAGES(2),
                    .SIGNED(0), .TAP_WIDTH(4))
        ud22 (.CLK(CLK), .RST(RST), .bus(ifd22));
    assign ifd02.A = da;  assign ifd02.B = db;  assign ifd02.IN_VALID = dvin;  assign ifd02.CE = dce;
    assign ifd22.A = da;  assign ifd22.B = db;  assign ifd22.IN_VALID = dvin;  assign ifd22.CE = dce;
    assign dv[2] = ifd02.OUT_VALID;
    assign dv[3] = ifd22.OUT_VALID;
    assign dz[2] = ifd02.Z;
    assign dz[3] = ifd22.Z;

`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
    assign ifd02.ACC_CLR = 1'b1;
    assign ifd22.ACC_CLR = 1'b1;
`endif

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        total++; if (if0.Z !== 18'd0)        begin bad++; $display("FAIL rst_z got=%0h exp=0", if0.Z); end
        total++; if (if0.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", if0.OUT_VALID); end
        total++; if (if0.XA !== 4'hF)        begin bad++; $display("FAIL rst_xa got=%0h exp=f", if0.XA); end
        total++; if (if0.XZ !== 4'h0)        begin bad++; $display("FAIL rst_xz got=%0h exp=0", if0.XZ); end
        total++; if (if1.Z !== 18'd0)        begin bad++; $display("FAIL rst_signed_z got=%0h exp=0", if1.Z); end
        total++; if (ifd22.Z !== 22'd0)      begin bad++; $display("FAIL rst_d22_z got=%0h exp=0", ifd22.Z); end
        total++; if (ifd22.XA !== 4'hF)      begin bad++; $display("FAIL rst_d22_xa got=%0h exp=f", ifd22.XA); end
        RST = 1'b0;
    endtask

    task automatic test_latency;
        logic [31:0] exp;
        @(negedge CLK);
        if0.A = 9'd3; if0.B = 9'd5; if0.IN_VALID = 1'b1;
        sb.push_back(32'd15);
        @(negedge CLK);
        total++; if (if0.XA !== 4'b1100)     begin bad++; $display("FAIL lat_xa got=%0h exp=c", if0.XA); end
        total++; if (if0.XZ !== 4'hF)        begin bad++; $display("FAIL lat_xz got=%0h exp=f", if0.XZ); end
        total++; if (if0.OUT_VALID !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%0b exp=0", if0.OUT_VALID); end
        if0.A = 9'd0; if0.B = 9'd0; if0.IN_VALID = 1'b0;
        @(negedge CLK);
        total++;
        if (if0.OUT_VALID !== 1'b1) begin
            bad++; $display("FAIL lat_valid got=%0b exp=1", if0.OUT_VALID);
        end else begin
            exp = sb.pop_front();
            total++; if (if0.Z !== exp[17:0]) begin bad++; $display("FAIL lat_z got=%0d exp=%0d", if0.Z, exp); end
        end
        @(negedge CLK);
        total++; if (if0.OUT_VALID !== 1'b0) begin bad++; $display("FAIL lat_single got=%0b exp=0", if0.OUT_VALID); end
        sb.delete();
    endtask

    task automatic test_signed;
        logic [8:0]  a_t [2];
        logic [8:0]  b_t [2];
        logic [31:0] z_t [2];
        logic [31:0] exp;
        int          nout;
        a_t = '{9'h100, 9'h100};
        b_t = '{9'h100, 9'h0FF};
        z_t = '{32'h10000, 32'h30100};
        nout = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (if1.OUT_VALID === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL signed_extra got=%0h exp=none", if1.Z);
                end else begin
                    exp = sb.pop_front();
                    nout++;
                    if (if1.Z !== exp[17:0]) begin bad++; $display("FAIL signed_z got=%0h exp=%0h", if1.Z, exp); end
                end
            end
            if (c < 2) begin
                if1.A = a_t[c]; if1.B = b_t[c]; if1.IN_VALID = 1'b1;
                sb.push_back(z_t[c]);
            end else begin
                if1.A = 9'd0; if1.B = 9'd0; if1.IN_VALID = 1'b0;
            end
        end
        total++; if (nout !== 2) begin bad++; $display("FAIL signed_count got=%0d exp=2", nout); end
        sb.delete();
    endtask

    task automatic test_ce_stall;
        bit          ce_t [10];
        bit          v_t  [10];
        logic [8:0]  a_t  [10];
        logic [31:0] exp;
        logic [17:0] last_z;
        bit          vm_in, vm_out, ce_prev;
        int          nout;
        ce_t = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        v_t  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        a_t  = '{9'd2, 9'd3, 9'd4, 9'd4, 9'd4, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
        vm_in = 0; vm_out = 0; ce_prev = 1; nout = 0; last_z = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            total++;
            if (if0.OUT_VALID !== vm_out) begin bad++; $display("FAIL stall_valid cyc=%0d got=%0b exp=%0b", i, if0.OUT_VALID, vm_out); end
            if (ce_prev && vm_out) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL stall_extra got=%0d exp=none", if0.Z);
                end else begin
                    exp = sb.pop_front();
                    last_z = exp[17:0];
                    nout++;
                    if (if0.Z !== exp[17:0]) begin bad++; $display("FAIL stall_z got=%0d exp=%0d", if0.Z, exp); end
                end
            end else if (!ce_prev && vm_out) begin
                total++;
                if (if0.Z !== last_z) begin bad++; $display("FAIL stall_hold got=%0d exp=%0d", if0.Z, last_z); end
            end
            if0.CE = ce_t[i]; if0.IN_VALID = v_t[i]; if0.A = a_t[i]; if0.B = a_t[i];
            if (ce_t[i]) begin
                if (v_t[i]) sb.push_back(32'(a_t[i]) * 32'(a_t[i]));
                vm_out = vm_in;
                vm_in  = v_t[i];
            end
            ce_prev = ce_t[i];
        end
        total++; if (nout !== 3)     begin bad++; $display("FAIL stall_count got=%0d exp=3", nout); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stall_left got=%0d exp=0", sb.size()); end
        sb.delete();
        if0.CE = 1'b1;
    endtask

    task automatic test_depth_sweep;
        int lat [4];
        lat = '{0, 2, 2, 4};
        @(negedge CLK);
        da = 18'h3FFFF; db = 4'hF; dvin = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                #1;
            end else begin
                @(negedge CLK);
            end
            for (int i = FIRST_D; i < 4; i++) begin
                total++;
                if (dv[i] !== (k == lat[i])) begin
                    bad++; $display("FAIL depth_valid inst=%0d cyc=%0d got=%0b exp=%0b", i, k, dv[i], (k == lat[i]));
                end else if (k == lat[i]) begin
                    total++;
                    if (dz[i] !== 22'h3BFFF1) begin bad++; $display("FAIL depth_z inst=%0d got=%0h exp=3bfff1", i, dz[i]); end
                end
            end
            if (k == 0) begin
                @(posedge CLK);
                #1;
                da = '0; db = '0; dvin = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] exp;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            total++;
            if (ifd22.OUT_VALID !== (i == 10)) begin
                bad++; $display("FAIL mid_valid cyc=%0d got=%0b exp=%0b", i, ifd22.OUT_VALID, (i == 10));
            end else if (i == 10) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL mid_extra got=%0h exp=none", ifd22.Z);
                end else begin
                    exp = sb.pop_front();
                    if (ifd22.Z !== exp[21:0]) begin bad++; $display("FAIL mid_new_z got=%0d exp=%0d", ifd22.Z, exp); end
                end
            end
            if (i >= 3 && i <= 9) begin
                total++; if (ifd22.Z !== 22'd0) begin bad++; $display("FAIL mid_z cyc=%0d got=%0h exp=0", i, ifd22.Z); end
            end
            RST = 1'b0; dvin = 1'b0; da = '0; db = '0;
            case (i)
                0: begin da = 18'd5; db = 4'd5; dvin = 1'b1; end
                1: begin da = 18'd6; db = 4'd6; dvin = 1'b1; end
                2: RST = 1'b1;
                6: begin da = 18'd3; db = 4'd3; dvin = 1'b1; sb.push_back(32'd9); end
                default: ;
            endcase
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL mid_left got=%0d exp=0", sb.size()); end
        sb.delete();
    endtask

`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
    task automatic test_accumulate;
        bit          v_t [9];
        bit          c_t [9];
        logic [8:0]  a_t [9];
        logic [8:0]  b_t [9];
        logic [17:0] acc_m, last_z;
        logic [31:0] exp;
        bit          vm_in, vm_out, seen;
        v_t = '{1, 1, 1, 0, 1, 0, 0, 0, 0};
        c_t = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        a_t = '{9'd2, 9'd4, 9'd1, 9'd9, 9'd7, 9'd0, 9'd0, 9'd0, 9'd0};
        b_t = '{9'd3, 9'd5, 9'd1, 9'd9, 9'd7, 9'd0, 9'd0, 9'd0, 9'd0};
        acc_m = '0; last_z = '0; vm_in = 0; vm_out = 0; seen = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            total++;
            if (if0.OUT_VALID !== vm_out) begin bad++; $display("FAIL acc_valid cyc=%0d got=%0b exp=%0b", i, if0.OUT_VALID, vm_out); end
            if (vm_out) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL acc_extra got=%0d exp=none", if0.Z);
                end else begin
                    exp = sb.pop_front();
                    last_z = exp[17:0];
                    seen = 1;
                    if (if0.Z !== exp[17:0]) begin bad++; $display("FAIL acc_z got=%0d exp=%0d", if0.Z, exp); end
                end
            end else if (seen) begin
                total++;
                if (if0.Z !== last_z) begin bad++; $display("FAIL acc_hold got=%0d exp=%0d", if0.Z, last_z); end
            end
            if0.IN_VALID = v_t[i]; if0.ACC_CLR = c_t[i]; if0.A = a_t[i]; if0.B = b_t[i];
            if (v_t[i]) begin
                acc_m = (c_t[i] ? 18'd0 : acc_m) + 18'(32'(a_t[i]) * 32'(b_t[i]));
                sb.push_back(32'(acc_m));
            end
            vm_out = vm_in;
            vm_in  = v_t[i];
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL acc_left got=%0d exp=0", sb.size()); end
        sb.delete();
        if0.ACC_CLR = 1'b1;
    endtask
`endif

    initial begin
        if0.CE = 1'b1; if0.IN_VALID = 1'b0; if0.A = '0; if0.B = '0;
        if1.CE = 1'b1; if1.IN_VALID = 1'b0; if1.A = '0; if1.B = '0;
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
        if0.ACC_CLR = 1'b1;
        if1.ACC_CLR = 1'b1;
`endif
        da = '0; db = '0; dvin = 1'b0; dce = 1'b1;

        test_reset();
        test_latency();
        test_signed();
        test_ce_stall();
        test_depth_sweep();
        test_reset_midflight();
`ifdef MULT_PIPE_TAP_ACCUMULATE_EN
        test_accumulate();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
